wb_result_unit: RTL
===================

// Module: wb_result_unit
// PURPOSE
//   Writeback end of the ALU/memory datapath. Takes the ALU result or the data
//   memory load return and drives the register-file write port (WriteData, WriteReg, RegWrite).
//   Waits for variable-latency load data, sign- or zero-extends sub-word loads,
//   and holds off new issue while a load is outstanding.
// PARAMETERS
//   DATA_W    64  datapath width (ALUResult, ReadData, WriteData)
//   REG_AW    5   register address width
//   ZERO_REG  31  register index (XZR) whose writes are suppressed
//   TIMEOUT   16  max cycles spent in WAIT_MEM before the load is abandoned (>=1)
// PORTS
//   clk          in   1       clock, all state on rising edge
//   reset        in   1       asynchronous, active-high reset
//   issue_valid  in   1       instruction result presented this cycle
//   issue_ready  out  1       unit accepts issue this cycle (comb: state!=WAIT_MEM)
//   ALUResult    in   DATA_W  ALU output
//   MemtoReg     in   1       1 = result comes from data memory (load)
//   RegWriteIn   in   1       instruction writes a register
//   WriteRegIn   in   REG_AW  destination register
//   MemSize      in   2       load size: 0=B,1=H,2=W,3=D
//   MemSigned    in   1       1 = sign-extend sub-word load
//   mem_rvalid   in   1       load data valid (sampled only in WAIT_MEM)
//   ReadData     in   DATA_W  load data, right-aligned
//   WriteData    out  DATA_W  register-file write data
//   WriteReg     out  REG_AW  register-file write address
//   RegWrite     out  1       register-file write enable, 1-cycle pulse per write
//   load_err     out  1       1-cycle pulse when a load times out
// BEHAVIOUR
//   - Reset: state IDLE; WriteData=0, WriteReg=0, RegWrite=0, load_err=0, timer=0.
//   - Issue accepted when issue_valid && issue_ready; fields latched on that edge.
//   - States: IDLE, WAIT_MEM, WRITE. issue_ready=1 in IDLE and WRITE.
//   - Accept, MemtoReg=0: -> WRITE; next cycle RegWrite=1, WriteData=ALUResult
//     (latency 1). Back-to-back ALU issues give one write per cycle.
//   - Accept, MemtoReg=1: -> WAIT_MEM, timer cleared. On mem_rvalid, capture
//     extended ReadData -> WRITE; RegWrite=1 the cycle after mem_rvalid.
//   - WRITE with no accept -> IDLE; RegWrite deasserts. WriteData/WriteReg hold.
//   - Extension: B/H/W take low 8/16/32 bits; MemSigned=1 replicates the top bit
//     of the field up to DATA_W, else zero-fill. D passes unchanged.
//   - RegWriteIn=0 or WriteRegIn==ZERO_REG: full sequence runs (loads still wait
//     for mem_rvalid), but RegWrite stays 0. WriteData/WriteReg still update.
//   - Timeout: timer counts cycles in WAIT_MEM without mem_rvalid. When it reaches
//     TIMEOUT: load_err=1 for 1 cycle, no write, -> IDLE. A mem_rvalid in the
//     cycle the timer reaches TIMEOUT wins (write, no error).
//   - mem_rvalid outside WAIT_MEM is ignored; it never produces a write.
//   - Reset mid-operation: pending load dropped, no write; late mem_rvalid ignored.
// CONFIGURATION
//   WB_BYPASS_EN defined: adds outputs fwd_valid(1), fwd_reg(REG_AW),
//     fwd_data(DATA_W). These equal RegWrite, WriteReg, WriteData each cycle so
//     the operand select path can bypass the register file. All reset to 0.
//   WB_BYPASS_EN undefined: ports absent; behaviour otherwise identical.
// TESTING
//   1 ALU write: issue ALUResult=64'h1234, WriteRegIn=5, RegWriteIn=1, MemtoReg=0
//     -> next cycle RegWrite=1, WriteReg=5, WriteData=64'h1234; then RegWrite=0.
//   2 Signed byte load: issue MemtoReg=1, MemSize=0, MemSigned=1; mem_rvalid 3 cycles
//     later with ReadData=64'h80 -> issue_ready=0 while waiting; next cycle
//     RegWrite=1, WriteData=64'hFFFF_FFFF_FFFF_FF80. Repeat MemSigned=0 -> 64'h80.
//   3 XZR and no-write: WriteRegIn=31, RegWriteIn=1 -> RegWrite never asserts;
//     RegWriteIn=0 with WriteRegIn=3 -> RegWrite never asserts.
//   4 Timeout: load issued, no mem_rvalid for 16 cycles -> load_err pulse, no
//     write, issue_ready=1. A mem_rvalid one cycle later -> no write.
//   5 Reset mid-load: reset asserted during WAIT_MEM -> all outputs 0 immediately;
//     mem_rvalid after release -> no write.
//   6 Back-to-back: 3 ALU issues on consecutive cycles (regs 1,2,3) -> 3
//     consecutive write pulses in order. With WB_BYPASS_EN, fwd_* mirror each write.

Source files
------------

// File: rtl/wb_result_unit.sv
// Writeback result unit: selects ALU or extended load data and drives the register-file write port.
// Optional WB_BYPASS_EN adds fwd_valid/fwd_reg/fwd_data mirrors of the write port for operand bypass.
module wb_result_unit #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              MemtoReg,
  input  logic              RegWriteIn,
  input  logic [REG_AW-1:0] WriteRegIn,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] WriteData,
  output logic [REG_AW-1:0] WriteReg,
  output logic              RegWrite,
  output logic              load_err
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_MEM = 2'd1;
  localparam logic [1:0] S_WRITE    = 2'd2;

  logic [1:0]        r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_we;
  logic [REG_AW-1:0] r_reg;

  logic [1:0]        w_state_nxt;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic [TMR_W-1:0]  w_timer_inc;
  logic [1:0]        w_size_nxt;
  logic              w_signed_nxt;
  logic              w_we_nxt;
  logic [REG_AW-1:0] w_reg_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [REG_AW-1:0] w_wreg_nxt;
  logic              w_regwrite_nxt;
  logic              w_load_err_nxt;
  logic              w_accept;
  logic              w_we_in;
  logic [DATA_W-1:0] w_ext;

  assign issue_ready = (r_state != S_WAIT_MEM);
  assign w_accept    = issue_valid && issue_ready;
  assign w_we_in     = RegWriteIn && (WriteRegIn != REG_AW'(ZERO_REG));
  assign w_timer_inc = r_timer + TMR_W'(1);

  // Sub-word load extension using the size/sign latched at issue
  always_comb begin
    w_ext = ReadData;
    case (r_size)
      2'd0:    w_ext = {{(DATA_W-8){r_signed & ReadData[7]}}, ReadData[7:0]};
      2'd1:    w_ext = {{(DATA_W-16){r_signed & ReadData[15]}}, ReadData[15:0]};
      2'd2:    w_ext = {{(DATA_W-32){r_signed & ReadData[31]}}, ReadData[31:0]};
      default: w_ext = ReadData;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_size_nxt     = r_size;
    w_signed_nxt   = r_signed;
    w_we_nxt       = r_we;
    w_reg_nxt      = r_reg;
    w_wdata_nxt    = WriteData;
    w_wreg_nxt     = WriteReg;
    w_regwrite_nxt = 1'b0;
    w_load_err_nxt = 1'b0;
    case (r_state)
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          w_wdata_nxt    = w_ext;
          w_wreg_nxt     = r_reg;
          w_regwrite_nxt = r_we;
          w_state_nxt    = S_WRITE;
        end else if (w_timer_inc == TMR_W'(TIMEOUT)) begin
          w_load_err_nxt = 1'b1;
          w_timer_nxt    = '0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      default: begin
        if (w_accept) begin
          w_size_nxt   = MemSize;
          w_signed_nxt = MemSigned;
          w_we_nxt     = w_we_in;
          w_reg_nxt    = WriteRegIn;
          if (MemtoReg) begin
            w_timer_nxt = '0;
            w_state_nxt = S_WAIT_MEM;
          end else begin
            w_wdata_nxt    = ALUResult;
            w_wreg_nxt     = WriteRegIn;
            w_regwrite_nxt = w_we_in;
            w_state_nxt    = S_WRITE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_size    <= 2'd0;
      r_signed  <= 1'b0;
      r_we      <= 1'b0;
      r_reg     <= '0;
      WriteData <= '0;
      WriteReg  <= '0;
      RegWrite  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_size    <= w_size_nxt;
      r_signed  <= w_signed_nxt;
      r_we      <= w_we_nxt;
      r_reg     <= w_reg_nxt;
      WriteData <= w_wdata_nxt;
      WriteReg  <= w_wreg_nxt;
      RegWrite  <= w_regwrite_nxt;
      load_err  <= w_load_err_nxt;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid = RegWrite;
  assign fwd_reg   = WriteReg;
  assign fwd_data  = WriteData;
`endif

endmodule
